// File: rtl/jt49_env_gen_if.sv
// Envelope generator bus: rate enable, period/shape
// register values, restart strobe and the level it returns.
interface jt49_env_gen_if #(
  parameter int PW = 16
);
  logic          cen;
  logic [PW-1:0] period;
  logic [3:0]    shape;
  logic          restart;
  logic [4:0]    env;
  logic          env_end;

  modport master (
    output cen,
    output period,
    output shape,
    output restart,
    input  env,
    input  env_end
  );

  modport slave (
    input  cen,
    input  period,
    input  shape,
    input  restart,
    output env,
    output env_end
  );
endinterface

// File: rtl/jt49_env_gen.sv
// AY-3-8910 style envelope: period prescaler, 32-step ramp
// and CONT/ATT/ALT/HOLD shape logic with restart on shape write.
module jt49_env_gen #(
  parameter int PW = 16
) (
  input logic            clk,
  input logic            rst_n,
  jt49_env_gen_if.slave  bus
);

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [PW-1:0] per_m1;
  logic [4:0]    step_q, step_d;
  logic [3:0]    shp_q, shp_d;
  logic          inv_q, inv_d;
  logic          hold_q, hold_d;
  logic          hlvl_q, hlvl_d;
  logic          tick;

  logic s_cont, s_att, s_alt, s_hold;
  assign s_cont = shp_q[3];
  assign s_att  = shp_q[2];
  assign s_alt  = shp_q[1];
  assign s_hold = shp_q[0];

  // period 0 is treated as period 1
  assign per_m1 = (bus.period == '0) ? '0
                : bus.period - PW'(1);
  assign tick   = bus.cen && (pcnt_q >= per_m1);

  always_comb begin
    pcnt_d = pcnt_q;
    step_d = step_q;
    shp_d  = shp_q;
    inv_d  = inv_q;
    hold_d = hold_q;
    hlvl_d = hlvl_q;
    if (bus.restart) begin
      pcnt_d = '0;
      step_d = '0;
      hold_d = 1'b0;
      shp_d  = bus.shape;
      inv_d  = bus.shape[2];
    end else if (bus.cen) begin
      pcnt_d = tick ? '0 : pcnt_q + PW'(1);
      if (tick && !hold_q) begin
        if (step_q != 5'd31) begin
          step_d = step_q + 5'd1;
        end else begin
          unique case (1'b1)
            !s_cont: begin
              hold_d = 1'b1;
              hlvl_d = 1'b0;
            end
            s_cont && s_hold: begin
              hold_d = 1'b1;
              hlvl_d = s_att ^ s_alt;
            end
            s_cont && !s_hold && s_alt: begin
              step_d = '0;
              inv_d  = ~inv_q;
            end
            default: begin
              step_d = '0;
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= '0;
      step_q <= '0;
      shp_q  <= '0;
      inv_q  <= 1'b0;
      hold_q <= 1'b1;
      hlvl_q <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      step_q <= step_d;
      shp_q  <= shp_d;
      inv_q  <= inv_d;
      hold_q <= hold_d;
      hlvl_q <= hlvl_d;
    end
  end

  assign bus.env     = hold_q ? {5{hlvl_q}}
                     : (inv_q ? step_q : ~step_q);
  assign bus.env_end = hold_q;

endmodule

// File: tb/tb_jt49_env_gen.sv
// Directed bench for jt49_env_gen; expected levels are
// queued as stimulus is applied and checked after each edge.
module tb_jt49_env_gen;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [5:0] sb[$];

  jt49_env_gen_if #(.PW(16)) bus ();

  jt49_env_gen #(.PW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag);
    logic [5:0] exp;
    logic [5:0] obs;
    exp = sb.pop_front();
    obs = {bus.env_end, bus.env};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: env=%0d end=%0b expected env=%0d end=%0b",
             tag, obs[4:0], obs[5], exp[4:0], exp[5]);
    end
  endtask

  task automatic tick(input logic c, input logic r,
                      input logic [4:0] ee, input logic eend,
                      input string tag);
    @(negedge clk);
    bus.cen     = c;
    bus.restart = r;
    sb.push_back({eend, ee});
    @(posedge clk);
    #1;
    bus.cen     = 1'b0;
    bus.restart = 1'b0;
    chk(tag);
  endtask

  initial begin
    int seg;
    int pos;
    logic [4:0] e;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.cen     = 1'b0;
    bus.restart = 1'b0;
    bus.period  = 16'd0;
    bus.shape   = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    sb.push_back({1'b1, 5'd0});
    chk("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // idle: no restart, envelope frozen at 0
    bus.period = 16'd1;
    for (int k = 0; k < 100; k++)
      tick(1'b1, 1'b0, 5'd0, 1'b1, "idle");

    // one-shot decay, period 2
    bus.period = 16'd2;
    bus.shape  = 4'h0;
    tick(1'b0, 1'b1, 5'd31, 1'b0, "decay_start");
    bus.shape  = 4'hF;
    for (int k = 1; k <= 70; k++) begin
      e = (k < 64) ? 5'(31 - k / 2) : 5'd0;
      tick(1'b1, 1'b0, e, k >= 64, "decay");
    end

    // triangle, period 0 acts as 1
    bus.period = 16'd0;
    bus.shape  = 4'hE;
    tick(1'b0, 1'b1, 5'd0, 1'b0, "tri_start");
    for (int k = 1; k <= 130; k++) begin
      seg = k / 32;
      pos = k % 32;
      e = (seg % 2 == 0) ? 5'(pos) : 5'(31 - pos);
      tick(1'b1, 1'b0, e, 1'b0, "triangle");
    end

    // decay then hold high
    bus.period = 16'd1;
    bus.shape  = 4'hB;
    tick(1'b0, 1'b1, 5'd31, 1'b0, "shB_start");
    for (int k = 1; k <= 40; k++) begin
      e = (k <= 31) ? 5'(31 - k) : 5'd31;
      tick(1'b1, 1'b0, e, k >= 32, "shapeB");
    end

    // attack then hold low
    bus.shape = 4'hF;
    tick(1'b0, 1'b1, 5'd0, 1'b0, "shF_start");
    for (int k = 1; k <= 40; k++) begin
      e = (k <= 31) ? 5'(k) : 5'd0;
      tick(1'b1, 1'b0, e, k >= 32, "shapeF");
    end

    // restart with cen in the same clk clears the prescaler
    bus.period = 16'd3;
    bus.shape  = 4'h8;
    tick(1'b0, 1'b1, 5'd31, 1'b0, "rc_start");
    for (int k = 1; k <= 42; k++)
      tick(1'b1, 1'b0, 5'(31 - k / 3), 1'b0, "rc_ramp");
    tick(1'b1, 1'b0, 5'd17, 1'b0, "rc_pre");
    tick(1'b1, 1'b1, 5'd31, 1'b0, "rc_same_clk");
    tick(1'b1, 1'b0, 5'd31, 1'b0, "rc_cen1");
    tick(1'b1, 1'b0, 5'd31, 1'b0, "rc_cen2");
    tick(1'b1, 1'b0, 5'd30, 1'b0, "rc_cen3");

    // asynchronous reset mid-ramp
    bus.period = 16'd1;
    bus.shape  = 4'h0;
    tick(1'b0, 1'b1, 5'd31, 1'b0, "ar_start");
    for (int k = 1; k <= 19; k++)
      tick(1'b1, 1'b0, 5'(31 - k), 1'b0, "ar_ramp");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb.push_back({1'b1, 5'd0});
    chk("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++)
      tick(1'b1, 1'b0, 5'd0, 1'b1, "post_reset");

    // period shrink while the prescaler is past the new limit
    bus.period = 16'd100;
    bus.shape  = 4'h0;
    tick(1'b0, 1'b1, 5'd31, 1'b0, "ps_start");
    for (int k = 0; k < 50; k++)
      tick(1'b1, 1'b0, 5'd31, 1'b0, "ps_wait");
    bus.period = 16'd10;
    tick(1'b1, 1'b0, 5'd30, 1'b0, "ps_first");
    for (int k = 1; k <= 20; k++) begin
      e = (k < 10) ? 5'd30 : ((k < 20) ? 5'd29 : 5'd28);
      tick(1'b1, 1'b0, e, 1'b0, "ps_every10");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/jt49_env_gen.md
Name: jt49_env_gen

Overview:
- Envelope generator for the JT49 PSG core.
- Sits directly downstream of the clock-enable divider. It consumes the divided enable pulse and produces the 5-bit envelope level used by the channel volume stage whenever a channel selects envelope mode.
- Implements the AY-3-8910 envelope: a 16-bit period prescaler, a 32-step ramp, and the CONT/ATT/ALT/HOLD shape logic with restart on shape write.

Parameters:
- PW, 16, width of period input and prescaler counter.

Ports:
- clk  input  1  system clock; all state on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- cen  input  1  envelope-rate clock enable from the divider stage; one clk wide.
- period  input  PW  envelope period register value; sampled live.
- shape  input  4  {CONT,ATT,ALT,HOLD} = shape[3:0]; latched only on restart.
- restart  input  1  one-clk pulse on shape-register write; independent of cen.
- env  output  5  envelope level 0..31; function of registered state only.
- env_end  output  1  high while the envelope is frozen (hold state).

Behaviour:
- Reset (rst_n low, async): prescaler=0, step=0, shape latch=0, inv=0, hold=1, hold level=0. Result: env=0, env_end=1 until the first restart.
- Prescaler: effective period P = max(period,1).
  - On cen: if pcnt >= P-1, then pcnt<=0 and an internal step pulse fires; otherwise pcnt<=pcnt+1.
  - So a step occurs every P cen pulses. Period 0 behaves as period 1.
  - period changes take effect immediately. If pcnt is already >= P-1, the next cen steps and clears pcnt.
- Restart (highest priority over cen and step):
  - pcnt<=0, step<=0, hold<=0, shape latch<=shape, inv<=shape[2] (ATT).
  - A cen in the same clk is discarded.
  - env shows the start level (ATT ? 0 : 31) from the edge that sampled restart.
- Level: when hold=0, env = inv ? step : 31-step. When hold=1, env = hold level.
- On a step pulse with hold=0 and step<31: step<=step+1.
- On a step pulse with hold=0 and step==31 (end of ramp), using the latched shape:
  - CONT=0: hold<=1, hold level=0.
  - CONT=1, HOLD=1: hold<=1, hold level = (ATT xor ALT) ? 31 : 0.
  - CONT=1, HOLD=0, ALT=1: step<=0, inv toggles (triangle; level at the ramp edge repeats once).
  - CONT=1, HOLD=0, ALT=0: step<=0, inv unchanged (sawtooth).
- While hold=1: the prescaler keeps counting, step pulses are ignored, and env is constant.
- env_end = hold.
- Latency: env and env_end change on the same clk edge that registers the triggering cen or restart. No additional pipeline stage.
- A write to shape without restart has no effect.
- rst_n asserted mid-ramp returns immediately to the reset state. No restart is implied on release.
- Width rules: step is 5-bit. The 31-step value is the bitwise inverse. The prescaler compare uses PW bits with no overflow; pcnt never exceeds PW'max.

Test Plan:
- Reset then idle: pulse cen for 100 clks with no restart -> env=0, env_end=1 throughout.
- period=2, shape=0x0, restart -> env=31 immediately. Then env decrements by 1 every 2 cen: 30 after cen#2, 0 after cen#62. After cen#64, env stays 0 and env_end=1.
- period=0, shape=0xE, restart -> env increments every cen pulse:
  - 0..31 over 31 cen, then 31..0 over the next 32 cen (31 shown twice), then 0..31 again.
  - Never holds; env_end=0.
- period=1, shape=0xB -> env decays 31..0, then env=31 held, env_end=1. Shape 0xF -> env rises 0..31, then env=0 held.
- Restart and cen in the same clk mid-ramp (env=17, shape 0x8) -> env=31 that edge. pcnt=0, so the next step comes after P further cen pulses, not P-1.
- Async reset mid-ramp (env=12): assert rst_n low between clk edges -> env=0 and env_end=1 without waiting for a clk edge. After release with no restart, env stays 0.
- Period shrink: period=100, pcnt=50, then write period=10 -> step on the next cen, then every 10 cen.
